// File: rtl/fp12_pkg.sv
// Shared FP12 definitions: field widths, bias, saturation magnitude and the
// 2^f mantissa table used when leaving the log domain.
package fp12_pkg;

  localparam int FP12_W      = 12;
  localparam int FP12_EXP_W  = 5;
  localparam int FP12_MANT_W = 6;
  localparam int FP12_EXP_BIAS = 15;
  localparam int FP12_EXP_MAX  = 30;

  localparam logic [FP12_EXP_W+FP12_MANT_W-1:0] FP12_MAX_FINITE_MAG = 11'h7BF;

  typedef struct packed {
    logic                   sign;
    logic [FP12_EXP_W-1:0]  exp;
    logic [FP12_MANT_W-1:0] mant;
  } fp12_t;

  // MANT_LUT[i] = min(63, round(64 * (2^(i/64) - 1)))
  localparam logic [FP12_MANT_W-1:0] MANT_LUT [64] = '{
    6'd0,  6'd1,  6'd1,  6'd2,  6'd3,  6'd4,  6'd4,  6'd5,
    6'd6,  6'd7,  6'd7,  6'd8,  6'd9,  6'd10, 6'd10, 6'd11,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd15, 6'd16, 6'd17, 6'd18,
    6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26,
    6'd27, 6'd27, 6'd28, 6'd29, 6'd31, 6'd32, 6'd33, 6'd34,
    6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42,
    6'd44, 6'd45, 6'd46, 6'd47, 6'd48, 6'd50, 6'd51, 6'd52,
    6'd53, 6'd55, 6'd56, 6'd57, 6'd59, 6'd60, 6'd61, 6'd63
  };

endpackage

// File: rtl/fp12_exp_mant_lut.sv
// 6-bit in / 6-bit out ROM mapping a rounded log fraction to the FP12 mantissa.
module fp12_exp_mant_lut
  import fp12_pkg::*;
(
  input  logic [FP12_MANT_W-1:0] idx,
  output logic [FP12_MANT_W-1:0] mant
);

  assign mant = MANT_LUT[idx];

endmodule

// File: rtl/fp12_partial_exp.sv
// Log2 magnitude + sign to packed FP12, three pipeline stages (split, table,
// range/pack) with a valid/ready chain where bubbles collapse.
module fp12_partial_exp
  import fp12_pkg::*;
#(
  parameter int LOG_W    = 16,
  parameter int FRAC_W   = 10,
  parameter int LUT_BITS = FP12_MANT_W,
  parameter int EXP_BIAS = FP12_EXP_BIAS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic [LOG_W-1:0] in_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_fp,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int INT_W = LOG_W - FRAC_W;
  localparam int E_W   = INT_W + 2;
  localparam int DROP  = FRAC_W - LUT_BITS;

  localparam logic [FRAC_W:0] RND_HALF =
    {{(FRAC_W - DROP + 1){1'b0}}, 1'b1, {(DROP - 1){1'b0}}};
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(EXP_BIAS);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(FP12_EXP_MAX + 1);

  // stage 1: split
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_sign_q, s1_sign_d;
  logic                       s1_zero_q, s1_zero_d;
  logic signed [INT_W:0]      s1_int_q, s1_int_d;
  logic [LUT_BITS-1:0]        s1_idx_q, s1_idx_d;

  // stage 2: table + bias
  logic                       s2_valid_q, s2_valid_d;
  logic                       s2_sign_q, s2_sign_d;
  logic                       s2_zero_q, s2_zero_d;
  logic signed [E_W-1:0]      s2_exp_q, s2_exp_d;
  logic [FP12_MANT_W-1:0]     s2_mant_q, s2_mant_d;

  // stage 3: packed result
  logic                       s3_valid_q, s3_valid_d;
  fp12_t                      s3_fp_q, s3_fp_d;
  logic                       s3_ovf_q, s3_ovf_d;
  logic                       s3_unf_q, s3_unf_d;

  logic                       s1_adv, s2_adv, s3_adv;
  logic [FRAC_W:0]            frac_rnd;
  logic signed [INT_W:0]      int_raw;
  logic [FP12_MANT_W-1:0]     lut_mant;
  logic [E_W-1:0]             sh_full;
  logic [2:0]                 sh3;
  logic [7:0]                 sub_sum, sub_v;
  fp12_t                      pk_fp;
  logic                       pk_ovf, pk_unf;

  fp12_exp_mant_lut u_lut (
    .idx  (s1_idx_q),
    .mant (lut_mant)
  );

  always_comb begin
    s3_adv = !s3_valid_q || out_ready;
    s2_adv = !s2_valid_q || s3_adv;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  // Half-up rounding of the fraction can carry into the integer part.
  always_comb begin
    frac_rnd = {1'b0, in_log[FRAC_W-1:0]} + RND_HALF;
    int_raw  = $signed({in_log[LOG_W-1], in_log[LOG_W-1:FRAC_W]});

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_int_d   = s1_int_q;
    s1_idx_d   = s1_idx_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_sign;
      s1_zero_d  = in_zero;
      s1_int_d   = int_raw + $signed({{INT_W{1'b0}}, frac_rnd[FRAC_W]});
      s1_idx_d   = frac_rnd[FRAC_W-1:DROP];
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_exp_d   = s2_exp_q;
    s2_mant_d  = s2_mant_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = s1_zero_q;
      s2_exp_d   = $signed({s1_int_q[INT_W], s1_int_q}) + E_BIAS;
      s2_mant_d  = lut_mant;
    end
  end

  // Subnormal path: shift {1,m} right by 1-e with half-up rounding; a
  // rounded result of 64 promotes to the smallest normal.
  always_comb begin
    sh_full = E_ONE - s2_exp_q;
    sh3     = sh_full[2:0];
    sub_sum = {2'b01, s2_mant_q} + (8'd1 << (sh3 - 3'd1));
    sub_v   = sub_sum >> sh3;

    pk_fp.sign = s2_sign_q;
    pk_fp.exp  = '0;
    pk_fp.mant = '0;
    pk_ovf     = 1'b0;
    pk_unf     = 1'b0;
    if (s2_zero_q) begin
      pk_ovf = 1'b0;
    end else if (s2_exp_q >= E_OVF) begin
      {pk_fp.exp, pk_fp.mant} = FP12_MAX_FINITE_MAG;
      pk_ovf = 1'b1;
    end else if (s2_exp_q >= E_ONE) begin
      pk_fp.exp  = s2_exp_q[FP12_EXP_W-1:0];
      pk_fp.mant = s2_mant_q;
    end else if (sh_full > E_W'(7) || sub_v == 8'd0) begin
      pk_unf = 1'b1;
    end else if (sub_v == 8'd64) begin
      pk_fp.exp = 5'd1;
    end else begin
      pk_fp.mant = sub_v[FP12_MANT_W-1:0];
    end
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_fp_d    = s3_fp_q;
    s3_ovf_d   = s3_ovf_q;
    s3_unf_d   = s3_unf_q;
    if (s3_adv) begin
      s3_valid_d = s2_valid_q;
      s3_fp_d    = pk_fp;
      s3_ovf_d   = pk_ovf;
      s3_unf_d   = pk_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_int_q   <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_fp_q    <= '0;
      s3_ovf_q   <= 1'b0;
      s3_unf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_int_q   <= s1_int_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= s2_mant_d;
      s3_valid_q <= s3_valid_d;
      s3_fp_q    <= s3_fp_d;
      s3_ovf_q   <= s3_ovf_d;
      s3_unf_q   <= s3_unf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_fp    = s3_fp_q;
  assign out_ovf   = s3_ovf_q;
  assign out_unf   = s3_unf_q;

endmodule

// File: tb/tb_fp12_partial_exp.sv
// Directed + random bench for fp12_partial_exp with a scoreboard queue and
// an independent real-arithmetic reference model.
module tb_fp12_partial_exp;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sign, in_zero, out_ready;
  logic [15:0] in_log;
  logic        in_ready, out_valid, out_ovf, out_unf;
  logic [11:0] out_fp;

  fp12_partial_exp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_log    (in_log),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic        zero;
    logic [15:0] lg;
    logic [13:0] exp;
    bit          chk_lat;
  } vec_t;

  typedef struct {
    logic [13:0] exp;
    int          t_acc;
    bit          chk_lat;
  } sb_t;

  vec_t        pend[$];
  sb_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          first_out = -1;
  int          last_out = -1;
  bit          feed_en = 1'b1;
  bit          hold_v = 1'b0;
  bit          saw_block = 1'b0;
  logic [13:0] hold_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, unf, fp12}
  function automatic logic [13:0] model(logic s, logic z, logic [15:0] lg);
    int li, ip, frac, idx, m, e, sh, v;
    logic [4:0] ex;
    logic [5:0] mn;
    logic ovf, unf;
    li   = int'($signed(lg));
    ip   = li >>> 10;
    frac = li & 1023;
    idx  = (frac + 8) / 16;
    if (idx == 64) begin
      ip++;
      idx = 0;
    end
    m = $rtoi(64.0 * ($pow(2.0, idx / 64.0) - 1.0) + 0.5);
    if (m > 63) m = 63;
    e = ip + 15;
    ex = 0; mn = 0; ovf = 0; unf = 0;
    if (z) begin
      ovf = 0;
    end else if (e >= 31) begin
      ex = 30; mn = 63; ovf = 1;
    end else if (e >= 1) begin
      ex = e[4:0]; mn = m[5:0];
    end else begin
      sh = 1 - e;
      if (sh > 7) unf = 1;
      else begin
        v = $rtoi($floor((64.0 + m) / $pow(2.0, sh) + 0.5));
        if (v == 0) unf = 1;
        else if (v == 64) ex = 1;
        else mn = v[5:0];
      end
    end
    return {ovf, unf, s, ex, mn};
  endfunction

  task automatic add(input logic s, input logic z, input logic [15:0] lg,
                     input logic [13:0] e, input bit lat);
    vec_t v;
    v.sign = s; v.zero = z; v.lg = lg; v.exp = e; v.chk_lat = lat;
    pend.push_back(v);
  endtask

  task automatic tick();
    sb_t  se;
    vec_t ve;
    if (feed_en && pend.size() > 0) begin
      in_valid = 1'b1;
      in_sign  = pend[0].sign;
      in_zero  = pend[0].zero;
      in_log   = pend[0].lg;
    end else begin
      in_valid = 1'b0;
      in_log   = 16'($urandom);
    end
    @(negedge clk);
    chk("in_ready", in_ready, !(sb.size() == 3 && !out_ready));
    if (hold_v) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {out_ovf, out_unf, out_fp}, hold_val);
    end
    if (out_valid && out_ready) begin
      chk("spurious_out", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        se = sb.pop_front();
        chk("out_data", {out_ovf, out_unf, out_fp}, se.exp);
        if (se.chk_lat) chk("latency", cyc - se.t_acc, 3);
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
    hold_v   = out_valid && !out_ready;
    hold_val = {out_ovf, out_unf, out_fp};
    if (in_valid && !in_ready) saw_block = 1'b1;
    if (in_valid && in_ready) begin
      ve = pend.pop_front();
      se.exp = ve.exp; se.t_acc = cyc; se.chk_lat = ve.chk_lat;
      sb.push_back(se);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && (pend.size() != 0 || sb.size() != 0); k++) tick();
    chk(tag, pend.size() + sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0;
    in_log = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fp", out_fp, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_unf", out_unf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    cyc = 10;

    // directed points, unstalled, latency checked
    out_ready = 1'b1;
    add(0, 0, 16'h0000, 14'h03C0, 1);
    add(1, 0, 16'h0000, 14'h0BC0, 1);
    add(0, 0, 16'h0200, 14'h03DB, 1);
    add(0, 0, 16'h0400, 14'h0400, 1);
    add(0, 0, 16'h03FF, 14'h0400, 1);
    add(0, 0, 16'hC400, 14'h0020, 1);
    add(0, 0, 16'hA800, 14'h1000, 1);
    add(0, 0, 16'h4000, 14'h27BF, 1);
    add(1, 1, 16'h1234, 14'h0800, 1);
    add(0, 0, 16'hC7F0, 14'h0040, 1);
    add(0, 0, 16'h3C00, 14'h0780, 1);
    add(1, 0, 16'h3FFF, 14'h2FBF, 1);
    add(0, 0, 16'hC200, model(0, 0, 16'hC200), 1);
    add(1, 0, 16'hBE00, model(1, 0, 16'hBE00), 1);
    drain("drain_directed", 80);

    // backpressure: 8 back-to-back words, consumer stalls cycles 4..9
    for (int k = 0; k < 8; k++) begin
      logic [15:0] lg;
      lg = 16'(k * 16'h0933 - 16'h2000);
      add(k[0], 0, lg, model(k[0], 0, lg), 0);
    end
    saw_block = 1'b0;
    for (int k = 0; k < 80 && (pend.size() != 0 || sb.size() != 0); k++) begin
      out_ready = !(k >= 4 && k <= 9);
      tick();
    end
    chk("bp_drain", pend.size() + sb.size(), 0);
    chk("bp_in_ready_dropped", saw_block, 1);

    // alternating consumer: one word every two cycles
    for (int k = 0; k < 10; k++) begin
      logic [15:0] lg;
      lg = 16'(16'h8000 + k * 16'h1717);
      add(1, 0, lg, model(1, 0, lg), 0);
    end
    n_out = 0; first_out = -1; last_out = -1;
    for (int k = 0; k < 100 && (pend.size() != 0 || sb.size() != 0); k++) begin
      out_ready = cyc[0];
      tick();
    end
    chk("alt_count", n_out, 10);
    chk("alt_rate", last_out - first_out, 18);

    // random traffic with random stalls and input gaps
    for (int k = 0; k < 40; k++) begin
      logic [15:0] lg;
      logic s, z;
      lg = 16'($urandom);
      s  = 1'($urandom_range(0, 1));
      z  = ($urandom_range(0, 9) == 0);
      add(s, z, lg, model(s, z, lg), 0);
    end
    for (int k = 0; k < 500 && (pend.size() != 0 || sb.size() != 0); k++) begin
      feed_en   = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    feed_en = 1'b1;
    chk("rand_drain", pend.size() + sb.size(), 0);

    // reset with three words in flight
    out_ready = 1'b0;
    add(0, 0, 16'h0100, model(0, 0, 16'h0100), 0);
    add(1, 0, 16'h0300, model(1, 0, 16'h0300), 0);
    add(0, 0, 16'h0500, model(0, 0, 16'h0500), 0);
    for (int k = 0; k < 12 && sb.size() < 3; k++) tick();
    chk("rst_inflight", sb.size(), 3);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1; cyc++;
    sb.delete();
    pend.delete();
    hold_v = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1; cyc++;
    repeat (6) tick();
    add(0, 0, 16'h0200, 14'h03DB, 1);
    drain("post_rst_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
